// File: rtl/ps2_tx_scheduler_if.sv
// Byte-source handshakes (ports A/B) and PS/2 line outputs of ps2_tx_scheduler.
`timescale 1ns/1ps
interface ps2_tx_scheduler_if;
   logic [7:0] a_data;
   logic       a_last;
   logic       a_valid;
   logic       a_ready;
   logic [7:0] b_data;
   logic       b_last;
   logic       b_valid;
   logic       b_ready;
   logic       ps2_clk;
   logic       ps2_data;
   logic       busy;
   logic [1:0] grant;

   modport master (
      output a_data, a_last, a_valid, b_data, b_last, b_valid,
      input  a_ready, b_ready, ps2_clk, ps2_data, busy, grant
   );

   modport slave (
      input  a_data, a_last, a_valid, b_data, b_last, b_valid,
      output a_ready, b_ready, ps2_clk, ps2_data, busy, grant
   );
endinterface

// File: rtl/ps2_tx_scheduler.sv
// Two-source round-robin PS/2 device-side transmitter with packet locking and lock timeout.
// Define PS2_INHIBIT_EN to add the ps2_inhibit input (host clock inhibit aborts/restarts frames).
`timescale 1ns/1ps
module ps2_tx_scheduler #(
   parameter int HALF_PERIOD  = 500,
   parameter int GAP_BITS     = 2,
   parameter int LOCK_TIMEOUT = 65535
) (
   input  logic clk,
   input  logic reset,
`ifdef PS2_INHIBIT_EN
   input  logic ps2_inhibit,
`endif
   ps2_tx_scheduler_if.slave bus
);

   localparam int BIT_CYCLES = 2 * HALF_PERIOD;
   localparam int GAP_CYCLES = GAP_BITS * BIT_CYCLES;
   localparam int PH_W       = $clog2(BIT_CYCLES);
   localparam int GAP_W      = $clog2(GAP_CYCLES);
   localparam int TO_W       = $clog2(LOCK_TIMEOUT + 1);

   localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(BIT_CYCLES - 1);
   localparam logic [PH_W-1:0]  PH_HALF   = PH_W'(HALF_PERIOD);
   localparam logic [PH_W-1:0]  HOLD_LAST = PH_W'(HALF_PERIOD - 1);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

   state_t           state_q, state_d;
   logic [PH_W-1:0]  phase_q, phase_d;
   logic [3:0]       bit_q, bit_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic [1:0]       grant_q, grant_d;
   logic             served_b_q, served_b_d;   // 1: port B was served last
   logic [7:0]       data_q, data_d;
   logic             last_q, last_d;
   logic             hold_q, hold_d;           // frame aborted, waiting to restart
   logic             ps2_clk_q, ps2_clk_d;
   logic             ps2_data_q, ps2_data_d;
   logic             busy_q, busy_d;
   logic             inhibit;
   logic             owner_valid;
   logic             pick_b;
   logic [10:0]      frame_d;

`ifdef PS2_INHIBIT_EN
   assign inhibit = ps2_inhibit;
`else
   assign inhibit = 1'b0;
`endif

   assign owner_valid = grant_q[1] ? bus.b_valid : bus.a_valid;
   assign pick_b      = bus.b_valid && (!bus.a_valid || !served_b_q);

   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
      state_d    = state_q;
      phase_d    = phase_q;
      bit_d      = bit_q;
      gap_d      = gap_q;
      to_d       = to_q;
      grant_d    = grant_q;
      served_b_d = served_b_q;
      data_d     = data_q;
      last_d     = last_q;
      hold_d     = hold_q;

      unique case (state_q)
         S_IDLE: begin
            if (grant_q != 2'b00) begin
               if (owner_valid && !inhibit) begin
                  state_d = S_LOAD;
                  to_d    = '0;
               end else if (!owner_valid) begin
                  if (to_q == TO_LAST) begin
                     grant_d = 2'b00;
                     to_d    = '0;
                  end else begin
                     to_d = to_q + 1'b1;
                  end
               end
            end else if (!inhibit && (bus.a_valid || bus.b_valid)) begin
               grant_d = pick_b ? 2'b10 : 2'b01;
               state_d = S_LOAD;
               to_d    = '0;
            end
         end

         S_LOAD: begin
            data_d     = grant_q[1] ? bus.b_data : bus.a_data;
            last_d     = grant_q[1] ? bus.b_last : bus.a_last;
            served_b_d = grant_q[1];
            to_d       = '0;
            phase_d    = '0;
            bit_d      = '0;
            hold_d     = 1'b0;
            state_d    = S_SHIFT;
         end

         S_SHIFT: begin
            if (inhibit) begin
               hold_d  = 1'b1;
               phase_d = '0;
               bit_d   = '0;
            end else if (hold_q) begin
               // Lines stay idle for one half-bit after inhibit release, then the frame restarts.
               if (phase_q == HOLD_LAST) begin
                  hold_d  = 1'b0;
                  phase_d = '0;
               end else begin
                  phase_d = phase_q + 1'b1;
               end
            end else if (phase_q == PH_LAST) begin
               phase_d = '0;
               if (bit_q == 4'd10) begin
                  bit_d   = '0;
                  gap_d   = '0;
                  state_d = S_GAP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end

         S_GAP: begin
            if (!inhibit) begin
               if (gap_q == GAP_LAST) begin
                  gap_d   = '0;
                  state_d = S_IDLE;
                  if (last_q) grant_d = 2'b00;
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Line levels are derived from next-state values and registered, so the pins never glitch.
      frame_d    = {1'b1, ~^data_d, data_d, 1'b0};
      ps2_clk_d  = 1'b1;
      ps2_data_d = 1'b1;
      if (state_d == S_SHIFT && !hold_d) begin
         ps2_clk_d  = (phase_d < PH_HALF);
         ps2_data_d = frame_d[bit_d];
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         phase_q    <= '0;
         bit_q      <= '0;
         gap_q      <= '0;
         to_q       <= '0;
         grant_q    <= 2'b00;
         served_b_q <= 1'b1;
         data_q     <= '0;
         last_q     <= 1'b0;
         hold_q     <= 1'b0;
         ps2_clk_q  <= 1'b1;
         ps2_data_q <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q    <= state_d;
         phase_q    <= phase_d;
         bit_q      <= bit_d;
         gap_q      <= gap_d;
         to_q       <= to_d;
         grant_q    <= grant_d;
         served_b_q <= served_b_d;
         data_q     <= data_d;
         last_q     <= last_d;
         hold_q     <= hold_d;
         ps2_clk_q  <= ps2_clk_d;
         ps2_data_q <= ps2_data_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.a_ready  = (state_q == S_LOAD) && grant_q[0];
   assign bus.b_ready  = (state_q == S_LOAD) && grant_q[1];
   assign bus.ps2_clk  = ps2_clk_q;
   assign bus.ps2_data = ps2_data_q;
   assign bus.busy     = busy_q;
   assign bus.grant    = grant_q;

endmodule

// File: tb/tb_ps2_tx_scheduler.sv
// Scoreboard bench for ps2_tx_scheduler: directed transfers, PS/2 frames decoded off the lines.
`timescale 1ns/1ps
module tb_ps2_tx_scheduler;
   localparam int HP = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
`ifdef PS2_INHIBIT_EN
   logic ps2_inhibit = 1'b0;
`endif

   ps2_tx_scheduler_if bus ();

   ps2_tx_scheduler #(.HALF_PERIOD(HP), .GAP_BITS(1), .LOCK_TIMEOUT(50)) dut (
      .clk        (clk),
      .reset      (reset),
`ifdef PS2_INHIBIT_EN
      .ps2_inhibit(ps2_inhibit),
`endif
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected 11-bit frames, bit i = i-th bit on the wire (start first).
   logic [10:0] exp_q[$];

   // Line monitor: decodes frames on ps2_clk falling edges and scores them.
   logic        prev_clk = 1'b1;
   logic [10:0] shreg = '0;
   int          bit_cnt = 0;
   int          low_len = 0;
   bit          in_low = 1'b0;
   int          frame_end_cyc = 0;
   int          falls = 0;
   int          a_pulses = 0;
   logic        inh_now;
   logic [10:0] exp_frame;

   always @(negedge clk) begin
`ifdef PS2_INHIBIT_EN
      inh_now = ps2_inhibit;
`else
      inh_now = 1'b0;
`endif
      if (bus.a_ready) a_pulses++;
      if (reset || inh_now) begin
         bit_cnt = 0;
         in_low  = 1'b0;
      end else if (prev_clk && !bus.ps2_clk) begin
         if (bit_cnt < 11) shreg[bit_cnt] = bus.ps2_data;
         bit_cnt++;
         in_low  = 1'b1;
         low_len = 1;
         falls++;
      end else if (in_low && !bus.ps2_clk) begin
         low_len++;
      end else if (in_low && bus.ps2_clk) begin
         in_low = 1'b0;
         check("ps2_clk_low_width", low_len, HP);
         if (bit_cnt >= 11) begin
            frame_end_cyc = cyc;
            bit_cnt = 0;
            check("frame_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               exp_frame = exp_q.pop_front();
               check("frame_bits", shreg, exp_frame);
            end
         end
      end
      prev_clk = bus.ps2_clk;
   end

   task automatic send(input bit pb, input logic [7:0] d, input bit l, output int acc);
      int t = 0;
      if (pb) begin
         bus.b_data = d; bus.b_last = l; bus.b_valid = 1'b1;
      end else begin
         bus.a_data = d; bus.a_last = l; bus.a_valid = 1'b1;
      end
      do begin
         @(negedge clk);
         t++;
      end while (!(pb ? bus.b_ready : bus.a_ready) && t < 2000);
      check(pb ? "b_ready_seen" : "a_ready_seen", t < 2000, 1);
      acc = cyc;
      check("grant_at_accept", bus.grant, pb ? 2'b10 : 2'b01);
      @(posedge clk);
      #1;
      if (pb) bus.b_valid = 1'b0; else bus.a_valid = 1'b0;
      @(negedge clk);
      check("ready_single_cycle", pb ? bus.b_ready : bus.a_ready, 0);
   endtask

   task automatic wait_busy_low(input string name);
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (bus.busy && t < 3000);
      check(name, bus.busy, 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   int t_a, t_b, t0, issue, base;

   initial begin
      bus.a_data = '0; bus.a_last = 1'b0; bus.a_valid = 1'b0;
      bus.b_data = '0; bus.b_last = 1'b0; bus.b_valid = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ps2_clk", bus.ps2_clk, 1);
      check("rst_ps2_data", bus.ps2_data, 1);
      check("rst_a_ready", bus.a_ready, 0);
      check("rst_b_ready", bus.b_ready, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_grant", bus.grant, 2'b00);
      @(posedge clk);
      #1 reset = 1'b0;

      // Single byte 0x1C from A: latency, frame, gap length
      exp_q.push_back(11'h438);
      issue = cyc;
      base  = a_pulses;
      send(1'b0, 8'h1C, 1'b1, t_a);
      check("ready_latency", t_a - issue, 1);
      check("start_bit_data", bus.ps2_data, 0);
      check("start_bit_clk", bus.ps2_clk, 1);
      check("busy_in_frame", bus.busy, 1);
      wait_busy_low("single_idle");
      check("gap_cycles", cyc - frame_end_cyc, 8);
      check("a_ready_pulses", a_pulses - base, 1);
      check("single_frames_done", exp_q.size(), 0);

      // Tie after reset: A first; A re-offers while B waits -> B wins the next tie
      do_reset();
      exp_q.push_back(11'h438);
      exp_q.push_back(11'h464);
      exp_q.push_back(11'h4EA);
      fork
         begin
            send(1'b0, 8'h1C, 1'b1, t_a);
            send(1'b0, 8'h75, 1'b1, t_a);
         end
         send(1'b1, 8'h32, 1'b1, t_b);
      join
      wait_busy_low("tie_idle");
      check("tie_frames_done", exp_q.size(), 0);

      // Packet lock: E0 (last=0) then 75 (last=1) from A, B waiting throughout
      do_reset();
      exp_q.push_back(11'h5C0);
      exp_q.push_back(11'h4EA);
      exp_q.push_back(11'h464);
      fork
         begin
            send(1'b0, 8'hE0, 1'b0, t_a);
            wait_busy_low("lock_idle");
            repeat (5) @(negedge clk);
            check("lock_grant_held", bus.grant, 2'b01);
            check("lock_b_blocked", bus.busy, 0);
            send(1'b0, 8'h75, 1'b1, t_a);
            wait_busy_low("lock_release_idle");
            check("lock_released", bus.grant, 2'b00);
         end
         send(1'b1, 8'h32, 1'b1, t_b);
      join
      wait_busy_low("lock_b_idle");
      check("lock_frames_done", exp_q.size(), 0);

      // Lock timeout: A stalls after E0, B accepted 51 cycles after IDLE entry
      do_reset();
      exp_q.push_back(11'h5C0);
      exp_q.push_back(11'h624);
      fork
         begin
            send(1'b0, 8'hE0, 1'b0, t_a);
            wait_busy_low("timeout_idle");
            t0 = cyc;
            while (cyc < t0 + 49) @(negedge clk);
            check("grant_before_timeout", bus.grant, 2'b01);
            @(negedge clk);
            check("grant_after_timeout", bus.grant, 2'b00);
         end
         send(1'b1, 8'h12, 1'b1, t_b);
      join
      check("timeout_accept_cycle", t_b - t0, 51);
      wait_busy_low("timeout_b_idle");
      check("timeout_grant_final", bus.grant, 2'b00);
      check("timeout_frames_done", exp_q.size(), 0);

      // Reset during data bit 3 of 0xAA: lines idle next cycle, byte dropped
      do_reset();
      send(1'b0, 8'hAA, 1'b1, t_a);
      while (cyc < t_a + 38) @(negedge clk);
      check("midframe_clk_low", bus.ps2_clk, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("midreset_ps2_clk", bus.ps2_clk, 1);
      check("midreset_ps2_data", bus.ps2_data, 1);
      check("midreset_busy", bus.busy, 0);
      check("midreset_grant", bus.grant, 2'b00);
      base = falls;
      repeat (300) @(negedge clk);
      check("no_retransmit", falls - base, 0);
      check("no_retransmit_busy", bus.busy, 0);

`ifdef PS2_INHIBIT_EN
      // Inhibit during bit 5 of 0x1C for 20 cycles: full frame restarts 4 cycles after release
      do_reset();
      exp_q.push_back(11'h438);
      send(1'b0, 8'h1C, 1'b1, t_a);
      while (cyc < t_a + 42) @(negedge clk);
      @(posedge clk);
      #1 ps2_inhibit = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("inhibit_clk_idle", bus.ps2_clk, 1);
      check("inhibit_data_idle", bus.ps2_data, 1);
      check("inhibit_busy", bus.busy, 1);
      check("inhibit_grant", bus.grant, 2'b01);
      repeat (18) @(posedge clk);
      #1 ps2_inhibit = 1'b0;
      t0 = cyc;
      while (cyc < t0 + 3) @(negedge clk);
      check("restart_not_early", bus.ps2_data, 1);
      @(negedge clk);
      check("restart_start_bit", bus.ps2_data, 0);
      check("restart_start_clk", bus.ps2_clk, 1);
      wait_busy_low("inhibit_idle");
      check("inhibit_frames_done", exp_q.size(), 0);
`endif

      check("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
